// File: rtl/scratchstack_ctrl.sv
// rtl/scratchstack_ctrl.sv - stack pointer owner and PUSH/POP/PEEK/REPLACE sequencer
// for a single-port, registered-read scratch stack RAM.
module scratchstack_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err,
  output logic [ADDR_W:0]   o_depth,
  output logic              o_empty,
  output logic              o_full,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  output logic              o_ram_wen,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RD1, S_RD2} state_t;

  localparam logic [1:0] OP_PUSH    = 2'b00;
  localparam logic [1:0] OP_POP     = 2'b01;
  localparam logic [1:0] OP_PEEK    = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;
  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state;
  logic [ADDR_W:0]   r_depth;
  logic              r_grow;
  logic              r_shrink;

  logic [ADDR_W-1:0] w_sp;
  logic [ADDR_W-1:0] w_top;
  logic              w_accept;

  assign w_sp        = r_depth[ADDR_W-1:0];
  assign w_top       = w_sp - ADDR_W'(1);
  assign o_cmd_ready = (r_state == S_IDLE) && !i_rst;
  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign o_depth     = r_depth;
  assign o_empty     = (r_depth == '0);
  assign o_full      = (r_depth == CAPACITY);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_depth     <= '0;
      r_grow      <= 1'b0;
      r_shrink    <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_wdata <= '0;
      o_ram_wen   <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_data  <= '0;
    end else begin
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_grow   <= (i_cmd_op == OP_PUSH);
            r_shrink <= (i_cmd_op == OP_POP);
            case (i_cmd_op)
              OP_PUSH, OP_REPLACE: begin
                if ((i_cmd_op == OP_PUSH) ? o_full : o_empty) begin
                  o_rsp_valid <= 1'b1;
                  o_rsp_err   <= 1'b1;
                end else begin
                  o_ram_addr  <= (i_cmd_op == OP_PUSH) ? w_sp : w_top;
                  o_ram_wdata <= i_cmd_data;
                  o_ram_wen   <= 1'b1;
                  r_state     <= S_WRITE;
                end
              end
              default: begin
                if (o_empty) begin
                  o_rsp_valid <= 1'b1;
                  o_rsp_err   <= 1'b1;
                end else begin
                  o_ram_addr <= w_top;
                  r_state    <= S_RD1;
                end
              end
            endcase
          end
        end
        S_WRITE: begin
          o_ram_wen   <= 1'b0;
          o_rsp_valid <= 1'b1;
          o_rsp_data  <= o_ram_wdata;
          if (r_grow) r_depth <= r_depth + 1'b1;
          r_state     <= S_IDLE;
        end
        // RAM latches the address at the end of RD1; its data is on i_ram_rdata in RD2.
        S_RD1: r_state <= S_RD2;
        S_RD2: begin
          o_rsp_valid <= 1'b1;
          o_rsp_data  <= i_ram_rdata;
          if (r_shrink) r_depth <= r_depth - 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
